// File: rtl/i2c_init_seq.sv
// i2c_init_seq: walks a ROM register table into an lsc_i2cm_16 master, then serves host accesses.
// Table entries are {ofs, data}; ofs FFFF ends the table, FFFE stalls for data*DELAY_UNIT clocks.
module i2c_init_seq #(
   parameter logic [6:0]  DEV_ADDR   = 7'h24,
   parameter logic [5:0]  INTERVAL   = 6'd29,
   parameter int          ROM_AW     = 8,
   parameter logic [15:0] DELAY_UNIT = 16'd24000
) (
   input  logic              clk,
   input  logic              resetn,
   input  logic              init_start,
   output logic              init_busy,
   output logic              init_done,
   output logic              init_err,
   output logic [ROM_AW-1:0] rom_addr,
   input  logic [23:0]       rom_data,
   input  logic              host_req,
   input  logic              host_rw,
   input  logic [15:0]       host_ofs,
   input  logic [7:0]        host_wdata,
   output logic              host_ack,
   output logic [7:0]        host_rdata,
   output logic              i2c_run,
   output logic              i2c_rw,
   output logic [6:0]        i2c_dev_addr,
   output logic [5:0]        i2c_interval,
   output logic [15:0]       i2c_ofs_addr,
   output logic [7:0]        i2c_wr_data,
   input  logic              i2c_running,
   input  logic              i2c_done,
   input  logic [7:0]        i2c_rd_data
);
   typedef enum logic [2:0] {IDLE, FETCH, DECODE, ISSUE, WAIT, DELAY, HOST_ISSUE, HOST_WAIT} state_t;
   state_t state, state_nx;
   logic [23:0] cnt;
   logic [15:0] rom_ofs;
   logic [7:0]  rom_dat;
   logic is_end, is_dly, adv, last, host_go;
   assign rom_ofs = rom_data[23:8];
   assign rom_dat = rom_data[7:0];
   assign is_end  = rom_ofs == 16'hFFFF;
   assign is_dly  = rom_ofs == 16'hFFFE;
   assign last    = &rom_addr;
   assign adv     = (state == DECODE && is_dly && rom_dat == 8'd0) ||
                    (state == WAIT && i2c_done) || (state == DELAY && cnt == 24'd1);
   // host_ack blocks re-entry so a host dropping req on the ack cycle is not served twice
   assign host_go = state == IDLE && !init_start && host_req && !host_ack;

   always_ff @(posedge clk or negedge resetn)
      if (!resetn) state <= IDLE;
      else state <= state_nx;

   always_comb begin
      state_nx = state;
      case (state)
         IDLE:       state_nx = init_start ? FETCH : host_go ? HOST_ISSUE : IDLE;
         FETCH:      state_nx = DECODE;
         DECODE:     state_nx = is_end ? IDLE : is_dly ? DELAY : ISSUE;
         ISSUE:      state_nx = i2c_running ? WAIT : ISSUE;
         WAIT:       state_nx = WAIT;
         DELAY:      state_nx = DELAY;
         HOST_ISSUE: state_nx = i2c_running ? HOST_WAIT : HOST_ISSUE;
         HOST_WAIT:  state_nx = i2c_done ? IDLE : HOST_WAIT;
         default:    state_nx = IDLE;
      endcase
      if (adv) state_nx = last ? IDLE : FETCH;
   end

   always_comb begin
      i2c_run      = state == ISSUE || state == HOST_ISSUE;
      init_busy    = state inside {FETCH, DECODE, ISSUE, WAIT, DELAY};
      i2c_dev_addr = DEV_ADDR;
      i2c_interval = INTERVAL;
   end

   always_ff @(posedge clk or negedge resetn)
      if (!resetn) begin
         rom_addr     <= '0;
         init_done    <= 1'b0;
         init_err     <= 1'b0;
         host_ack     <= 1'b0;
         host_rdata   <= 8'd0;
         i2c_rw       <= 1'b0;
         i2c_ofs_addr <= 16'd0;
         i2c_wr_data  <= 8'd0;
         cnt          <= 24'd0;
      end else begin
         init_done <= (state == DECODE && is_end) || (adv && last);
         host_ack  <= state == HOST_WAIT && i2c_done;
         if (state == IDLE && init_start) begin
            rom_addr <= '0;
            init_err <= 1'b0;
         end else if (adv) begin
            if (last) init_err <= 1'b1;
            else rom_addr <= rom_addr + 1'b1;
         end
         if (state == DECODE) cnt <= 24'(rom_dat) * 24'(DELAY_UNIT);
         else if (state == DELAY) cnt <= cnt - 24'd1;
         if (state == DECODE && !is_end && !is_dly) begin
            i2c_ofs_addr <= rom_ofs;
            i2c_wr_data  <= rom_dat;
            i2c_rw       <= 1'b0;
         end else if (host_go) begin
            i2c_ofs_addr <= host_ofs;
            i2c_wr_data  <= host_wdata;
            i2c_rw       <= host_rw;
         end
         if (state == HOST_WAIT && i2c_done && i2c_rw) host_rdata <= i2c_rd_data;
      end
endmodule

// File: tb/tb_i2c_init_seq.sv
// tb_i2c_init_seq: table vectors, random tables and host accesses against a behavioural table-walk model.
module tb_i2c_init_seq;
   logic clk = 1'b0;
   logic resetn = 1'b0;
   logic init_start = 1'b0;
   logic init_busy, init_done, init_err;
   logic [1:0] rom_addr;
   logic [23:0] rom_data;
   logic host_req = 1'b0, host_rw = 1'b0;
   logic [15:0] host_ofs = 16'd0;
   logic [7:0] host_wdata = 8'd0;
   logic host_ack;
   logic [7:0] host_rdata;
   logic i2c_run, i2c_rw;
   logic [6:0] i2c_dev_addr;
   logic [5:0] i2c_interval;
   logic [15:0] i2c_ofs_addr;
   logic [7:0] i2c_wr_data;
   logic i2c_running, i2c_done;
   logic [7:0] i2c_rd_data;

   always #5 clk = ~clk;

   i2c_init_seq #(.DEV_ADDR(7'h24), .INTERVAL(6'd29), .ROM_AW(2), .DELAY_UNIT(16'd10)) dut (
      .clk(clk), .resetn(resetn), .init_start(init_start), .init_busy(init_busy),
      .init_done(init_done), .init_err(init_err), .rom_addr(rom_addr), .rom_data(rom_data),
      .host_req(host_req), .host_rw(host_rw), .host_ofs(host_ofs), .host_wdata(host_wdata),
      .host_ack(host_ack), .host_rdata(host_rdata), .i2c_run(i2c_run), .i2c_rw(i2c_rw),
      .i2c_dev_addr(i2c_dev_addr), .i2c_interval(i2c_interval), .i2c_ofs_addr(i2c_ofs_addr),
      .i2c_wr_data(i2c_wr_data), .i2c_running(i2c_running), .i2c_done(i2c_done),
      .i2c_rd_data(i2c_rd_data)
   );

   typedef struct {
      string name;
      logic [3:0][23:0] tbl;
      int n_wr;
      logic err;
   } vec_t;
   vec_t vecs[6];

   logic [23:0] rom [4];
   logic [24:0] log_q[$];
   logic [24:0] exp_q[$];
   logic exp_err;
   int exp_first;
   int checks = 0, errors = 0;
   int cyc = 0, t_run = 0, done_cnt = 0, viol = 0, m_cnt = 0;
   logic run_seen = 1'b0, prev_done = 1'b0, m_busy;
   logic [7:0] mrd = 8'd0, hr_exp = 8'd0;

   always @(posedge clk) rom_data <= rom[rom_addr];
   always @(posedge clk) cyc <= cyc + 1;
   assign i2c_rd_data = mrd;

   // master model: accepts run when idle, logs the transfer, finishes after a random latency
   always @(posedge clk or negedge resetn)
      if (!resetn) begin
         m_busy <= 1'b0;
         i2c_running <= 1'b0;
         i2c_done <= 1'b0;
      end else begin
         i2c_done <= 1'b0;
         if (!m_busy && i2c_run) begin
            m_busy <= 1'b1;
            i2c_running <= 1'b1;
            m_cnt <= $urandom_range(0, 4);
            log_q.push_back({i2c_rw, i2c_ofs_addr, i2c_wr_data});
         end else if (m_busy) begin
            if (m_cnt == 0) begin
               i2c_done <= 1'b1;
               i2c_running <= 1'b0;
               m_busy <= 1'b0;
            end else m_cnt <= m_cnt - 1;
         end
      end

   always @(negedge clk) begin
      if (resetn && prev_done && i2c_run) viol++;
      prev_done = i2c_done;
      if (init_done) done_cnt++;
      if (i2c_run && !run_seen) begin
         run_seen = 1'b1;
         t_run = cyc;
      end
   end

   task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
      checks++;
      if (a !== e) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", n, a, e);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   function automatic vec_t mk(input string n, input logic [23:0] a, b, c, d, input int nw, input logic e);
      vec_t v;
      v.name = n;
      v.tbl = {d, c, b, a};
      v.n_wr = nw;
      v.err = e;
      return v;
   endfunction

   // walk the table as the rules describe: writes in order, delays add stall, end marker stops
   function automatic void model();
      int t;
      logic [15:0] o;
      logic [7:0] d;
      exp_q.delete();
      exp_err = 1'b1;
      exp_first = -1;
      t = 1;
      for (int i = 0; i < 4; i++) begin
         o = rom[i][23:8];
         d = rom[i][7:0];
         if (o == 16'hFFFF) begin
            exp_err = 1'b0;
            break;
         end
         t += 2;
         if (o == 16'hFFFE) t += int'(d) * 10;
         else begin
            if (exp_first < 0) exp_first = t;
            exp_q.push_back({1'b0, o, d});
         end
      end
   endfunction

   task automatic check_reset(input string tag);
      chk({tag, "_run"}, 32'(i2c_run), 0);
      chk({tag, "_busy"}, 32'(init_busy), 0);
      chk({tag, "_done"}, 32'(init_done), 0);
      chk({tag, "_err"}, 32'(init_err), 0);
      chk({tag, "_rom_addr"}, 32'(rom_addr), 0);
      chk({tag, "_ack"}, 32'(host_ack), 0);
      chk({tag, "_rdata"}, 32'(host_rdata), 0);
      chk({tag, "_rw"}, 32'(i2c_rw), 0);
      chk({tag, "_ofs"}, 32'(i2c_ofs_addr), 0);
      chk({tag, "_wdata"}, 32'(i2c_wr_data), 0);
      chk({tag, "_dev"}, 32'(i2c_dev_addr), 32'h24);
      chk({tag, "_intv"}, 32'(i2c_interval), 29);
   endtask

   task automatic run_table(input string name, input int n_exp, input logic err_exp, input bit rs);
      int s, n;
      model();
      log_q.delete();
      done_cnt = 0;
      run_seen = 1'b0;
      init_start = 1'b1;
      s = cyc;
      tick;
      init_start = 1'b0;
      chk({name, "_busy_start"}, 32'(init_busy), 1);
      chk({name, "_err_clear"}, 32'(init_err), 0);
      if (rs) begin
         repeat (6) tick;
         init_start = 1'b1;
         tick;
         init_start = 1'b0;
      end
      n = 0;
      while (done_cnt == 0 && n < 3000) begin
         tick;
         n++;
      end
      chk({name, "_done_seen"}, 32'(done_cnt != 0), 1);
      repeat (3) tick;
      chk({name, "_done_once"}, 32'(done_cnt), 1);
      chk({name, "_err"}, 32'(init_err), 32'(err_exp));
      chk({name, "_busy_end"}, 32'(init_busy), 0);
      chk({name, "_n_wr"}, 32'(log_q.size()), 32'(n_exp));
      for (int i = 0; i < log_q.size() && i < exp_q.size(); i++)
         chk({name, "_xfer"}, 32'(log_q[i]), 32'(exp_q[i]));
      if (exp_first >= 0) chk({name, "_first_run"}, 32'(t_run - s), 32'(exp_first));
   endtask

   task automatic host_access(input logic rw, input logic [15:0] ofs, input logic [7:0] wd);
      int n;
      n = 0;
      host_rw = rw;
      host_ofs = ofs;
      host_wdata = wd;
      host_req = 1'b1;
      while (!host_ack && n < 3000) begin
         @(negedge clk);
         n++;
      end
      chk("host_ack_seen", 32'(host_ack), 1);
      host_req = 1'b0;
      if (rw) hr_exp = mrd;
      chk("host_rdata", 32'(host_rdata), 32'(hr_exp));
      chk("host_rw", 32'(i2c_rw), 32'(rw));
      chk("host_xfer", log_q.size() == 0 ? 32'hFFFF_FFFF : 32'(log_q[$]), 32'({rw, ofs, wd}));
      @(negedge clk);
      chk("host_ack_pulse", 32'(host_ack), 0);
      @(posedge clk);
      #1;
   endtask

   initial begin
      int n, r;
      vecs[0] = mk("basic", 24'h300012, 24'h300134, 24'hFFFF00, 24'h000000, 2, 1'b0);
      vecs[1] = mk("delay2", 24'hFFFE02, 24'h010001, 24'hFFFF00, 24'h000000, 1, 1'b0);
      vecs[2] = mk("delay0", 24'hFFFE00, 24'h010001, 24'hFFFF00, 24'h000000, 1, 1'b0);
      vecs[3] = mk("noend", 24'h1000AA, 24'h1001BB, 24'h1002CC, 24'h1003DD, 4, 1'b1);
      vecs[4] = mk("endfirst", 24'hFFFF00, 24'h123456, 24'h000000, 24'h000000, 0, 1'b0);
      vecs[5] = mk("delay_last", 24'h200001, 24'h200102, 24'h200203, 24'hFFFE01, 3, 1'b1);
      for (int i = 0; i < 4; i++) rom[i] = 24'h0;
      repeat (3) tick;
      check_reset("rst_held");
      resetn = 1'b1;
      tick;
      check_reset("rst_rel");

      for (int v = 0; v < 6; v++) begin
         for (int i = 0; i < 4; i++) rom[i] = vecs[v].tbl[i];
         run_table(vecs[v].name, vecs[v].n_wr, vecs[v].err, v == 1);
      end

      mrd = 8'hA5;
      host_access(1'b1, 16'h0005, 8'h00);
      host_access(1'b0, 16'h0010, 8'h77);
      for (int k = 0; k < 4; k++) begin
         mrd = 8'($urandom);
         host_access(1'($urandom), 16'($urandom), 8'($urandom));
      end

      for (int i = 0; i < 4; i++) rom[i] = vecs[0].tbl[i];
      model();
      log_q.delete();
      done_cnt = 0;
      mrd = 8'h5A;
      host_rw = 1'b1;
      host_ofs = 16'h0042;
      host_wdata = 8'h00;
      host_req = 1'b1;
      init_start = 1'b1;
      tick;
      init_start = 1'b0;
      chk("both_table_first", 32'(init_busy), 1);
      host_access(1'b1, 16'h0042, 8'h00);
      chk("both_done_once", 32'(done_cnt), 1);
      chk("both_n_xfer", 32'(log_q.size()), 3);
      if (log_q.size() == 3) begin
         chk("both_xfer0", 32'(log_q[0]), 32'h0_300012);
         chk("both_xfer1", 32'(log_q[1]), 32'h0_300134);
      end

      for (int k = 0; k < 10; k++) begin
         for (int i = 0; i < 4; i++) begin
            r = $urandom_range(0, 9);
            if (r < 6) rom[i] = {16'($urandom_range(0, 65533)), 8'($urandom)};
            else if (r < 8) rom[i] = {16'hFFFE, 8'($urandom_range(0, 3))};
            else rom[i] = {16'hFFFF, 8'($urandom)};
         end
         model();
         run_table("rand", exp_q.size(), exp_err, 1'b0);
      end

      for (int i = 0; i < 4; i++) rom[i] = vecs[3].tbl[i];
      log_q.delete();
      init_start = 1'b1;
      tick;
      init_start = 1'b0;
      n = 0;
      while (!i2c_running && n < 200) begin
         tick;
         n++;
      end
      chk("rst_mid_running", 32'(i2c_running), 1);
      tick;
      resetn = 1'b0;
      #1;
      check_reset("rst_async");
      tick;
      resetn = 1'b1;
      tick;
      hr_exp = 8'd0;
      run_table("after_rst", 4, 1'b1, 1'b0);

      chk("run_after_done", 32'(viol), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
